// File: rtl/crack_pkg.sv
// crack_pkg: host controller states and cracker report/hash sizes.
// Shared by crack_host_ctrl and handshake_strobe.
package crack_pkg;

  localparam int PW_BYTES     = 20;
  localparam int HASH_BYTES   = 16;
  localparam int REPORT_BYTES = 21;

  typedef enum logic [3:0] {
    IDLE,
    UP_LOAD,
    UP_WAIT_TURN,
    UP_STROBE,
    UP_NEXT,
    GO_STROBE,
    CRACK_WAIT,
    RX_CAPTURE,
    RX_HOLD,
    RX_ACK,
    DRAIN,
    ERROR
  } host_state_e;

endpackage

// File: rtl/handshake_strobe.sv
// handshake_strobe: raise-until-your_turn-low strobe for store/go.
// Watchdog present only with CRACK_HOST_TIMEOUT_EN defined.
module handshake_strobe
  import crack_pkg::*;
`ifdef CRACK_HOST_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic sel_store,
  input  logic your_turn,
`ifdef CRACK_HOST_TIMEOUT_EN
  input  logic wait_rise,
  output logic timeout,
`endif
  output logic store,
  output logic go,
  output logic done
);

  logic active;
  logic kill;

  assign active = store | go;
  assign done   = active & ~your_turn;

`ifdef CRACK_HOST_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        expired;
  logic        waiting;

  // Counts a stalled fall after a strobe, or a stalled rise before one.
  assign waiting = active ? your_turn : (wait_rise & ~your_turn);
  assign timeout = waiting &&
                   (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign kill    = timeout | expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      expired <= 1'b0;
    end else begin
      wd_cnt  <= waiting ? wd_cnt + 16'd1 : 16'd0;
      expired <= expired | timeout;
    end
  end
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      store <= 1'b0;
      go    <= 1'b0;
    end else if (done) begin
      store <= 1'b0;
      go    <= 1'b0;
    end else if (req && !active && your_turn) begin
      store <= sel_store;
      go    <= ~sel_store;
    end
  end

endmodule

// File: rtl/crack_host_ctrl.sv
// crack_host_ctrl: uploads hashes, starts the cracker, collects reports.
// Optional watchdog/ERROR state with CRACK_HOST_TIMEOUT_EN defined.
module crack_host_ctrl
  import crack_pkg::*;
#(
  parameter int MAX_HASHES = 64
`ifdef CRACK_HOST_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hash_valid,
  output logic         hash_ready,
  input  logic [127:0] hash_data,
  input  logic         start,
  output logic [7:0]   new_hash_byte,
  output logic         store_hash_byte,
  output logic         go,
  input  logic         your_turn,
  input  logic         match_found,
  input  logic [7:0]   password_byte,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [159:0] result_chars,
  output logic [4:0]   result_len,
  output logic [6:0]   hash_count,
  output logic         cracking,
  output logic         error
);

  host_state_e state, state_n;

  logic [127:0]          hash_sr;
  logic [3:0]            up_idx;
  logic [4:0]            rx_idx;
  logic [PW_BYTES*8-1:0] pw_buf;
  logic [4:0]            pw_len;
  logic                  hash_rdy_q;
  logic                  hash_fire;
  logic                  up_last;
  logic [6:0]            count_n;
  logic                  req;
  logic                  sel_store;
  logic                  hs_done;

  // start and a pending report both take priority over an upload
  assign hash_ready = hash_rdy_q & ~start & ~match_found;
  assign hash_fire  = hash_valid & hash_ready;
  assign up_last    = (up_idx == 4'(HASH_BYTES - 1));
  assign count_n    = hash_count +
                      {6'd0, state == UP_NEXT && up_last};

`ifdef CRACK_HOST_TIMEOUT_EN
  logic timeout;

  handshake_strobe #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_strobe (
    .clk(clk),
    .rst(rst),
    .req(req),
    .sel_store(sel_store),
    .your_turn(your_turn),
    .wait_rise(state == UP_WAIT_TURN),
    .timeout(timeout),
    .store(store_hash_byte),
    .go(go),
    .done(hs_done)
  );

  always_ff @(posedge clk) begin
    if (rst) error <= 1'b0;
    else if (timeout) error <= 1'b1;
  end
`else
  handshake_strobe u_strobe (
    .clk(clk),
    .rst(rst),
    .req(req),
    .sel_store(sel_store),
    .your_turn(your_turn),
    .store(store_hash_byte),
    .go(go),
    .done(hs_done)
  );

  assign error = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    req       = 1'b0;
    sel_store = 1'b0;
    unique case (state)
      IDLE: begin
        if (match_found) state_n = DRAIN;
        else if (start) state_n = GO_STROBE;
        else if (hash_fire) state_n = UP_LOAD;
      end
      UP_LOAD: state_n = UP_WAIT_TURN;
      UP_WAIT_TURN: begin
        req       = ~match_found;
        sel_store = 1'b1;
        if (your_turn && !match_found) state_n = UP_STROBE;
      end
      UP_STROBE: begin
        sel_store = 1'b1;
        if (hs_done) state_n = UP_NEXT;
      end
      UP_NEXT: state_n = up_last ? IDLE : UP_WAIT_TURN;
      GO_STROBE: begin
        req = 1'b1;
        if (hs_done) state_n = CRACK_WAIT;
      end
      CRACK_WAIT: begin
        if (your_turn && match_found) state_n = RX_CAPTURE;
      end
      RX_CAPTURE: begin
        req     = (rx_idx < 5'(PW_BYTES));
        state_n = req ? RX_ACK : RX_HOLD;
      end
      RX_HOLD: begin
        if (!result_valid) begin
          req     = 1'b1;
          state_n = RX_ACK;
        end
      end
      RX_ACK: begin
        req = 1'b1;
        if (hs_done) state_n = CRACK_WAIT;
      end
      DRAIN: begin
        req = match_found;
        if (!hs_done && !store_hash_byte && !go &&
            your_turn && !match_found)
          state_n = IDLE;
      end
      ERROR: ;
      default: state_n = IDLE;
    endcase
`ifdef CRACK_HOST_TIMEOUT_EN
    if (timeout) state_n = ERROR;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hash_sr       <= '0;
      up_idx        <= '0;
      rx_idx        <= '0;
      pw_buf        <= '0;
      pw_len        <= '0;
      hash_rdy_q    <= 1'b0;
      new_hash_byte <= '0;
      result_valid  <= 1'b0;
      result_chars  <= '0;
      result_len    <= '0;
      hash_count    <= '0;
      cracking      <= 1'b0;
    end else begin
      state      <= state_n;
      hash_count <= count_n;
      hash_rdy_q <= (state_n == IDLE) &&
                    (count_n < 7'(MAX_HASHES));
      if (hash_fire) hash_sr <= hash_data;
      if (state == UP_LOAD) up_idx <= '0;
      if (state == UP_WAIT_TURN && state_n == UP_STROBE)
        new_hash_byte <= hash_sr[127:120];
      if (state == UP_NEXT) begin
        hash_sr <= {hash_sr[119:0], 8'h00};
        up_idx  <= up_idx + 4'd1;
      end
      if (state == RX_CAPTURE) begin
        if (rx_idx < 5'(PW_BYTES))
          pw_buf[{rx_idx, 3'b000} +: 8] <= password_byte;
        else
          pw_len <= password_byte[4:0];
      end
      if (state == RX_HOLD && !result_valid) begin
        result_chars <= pw_buf;
        result_len   <= pw_len;
        result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      if (state == RX_ACK && hs_done)
        rx_idx <= (rx_idx == 5'(REPORT_BYTES - 1)) ?
                  5'd0 : rx_idx + 5'd1;
      if ((state == GO_STROBE && hs_done) ||
          (state == IDLE && state_n == DRAIN))
        cracking <= 1'b1;
    end
  end

endmodule
